// File: rtl/inst_decode_stage_pkg.sv
// Shared CPU definitions: immediate formats, opcodes,
// decode-buffer states and the buffered entry layout.
package cpu_defs;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    fmt_e        fmt;
    logic        illegal;
  } dec_ent_t;

endpackage

// File: rtl/inst_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master = fetch/execute environment, slave = decode stage.
interface inst_decode_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc,
    input  out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc,
    output out_imm, out_fmt, out_illegal
  );

endinterface

// File: rtl/inst_immediate_decode.sv
// Builds every sign-extended RV32 immediate from one instruction word.
// Bits [6:0] carry no immediate data and are not taken.
module inst_immediate_decode (
  input  logic [31:7] i_inst,
  output logic [31:0] o_imm_i,
  output logic [31:0] o_imm_s,
  output logic [31:0] o_imm_b,
  output logic [31:0] o_imm_u,
  output logic [31:0] o_imm_j
);

  assign o_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};

  assign o_imm_s = {{20{i_inst[31]}},
                    i_inst[31:25], i_inst[11:7]};

  assign o_imm_b = {{19{i_inst[31]}}, i_inst[31],
                    i_inst[7], i_inst[30:25],
                    i_inst[11:8], 1'b0};

  assign o_imm_u = {i_inst[31:12], 12'b0};

  assign o_imm_j = {{11{i_inst[31]}}, i_inst[31],
                    i_inst[19:12], i_inst[20],
                    i_inst[30:21], 1'b0};

endmodule

// File: rtl/inst_opcode_classify.sv
// Combinational opcode classifier: immediate format and illegal flag.
// Every legal opcode ends in 2'b11, so compressed encodings fall to illegal.
module inst_opcode_classify
  import cpu_defs::*;
(
  input  logic [6:0] i_opcode,
  output fmt_e       o_fmt,
  output logic       o_illegal
);

  always_comb begin
    o_fmt     = FMT_R;
    o_illegal = 1'b0;
    unique case (1'b1)
      (i_opcode == OPC_LUI) ||
      (i_opcode == OPC_AUIPC):    o_fmt = FMT_U;
      (i_opcode == OPC_JAL):      o_fmt = FMT_J;
      (i_opcode == OPC_JALR)   ||
      (i_opcode == OPC_LOAD)   ||
      (i_opcode == OPC_OP_IMM) ||
      (i_opcode == OPC_MISC_MEM) ||
      (i_opcode == OPC_SYSTEM):   o_fmt = FMT_I;
      (i_opcode == OPC_STORE):    o_fmt = FMT_S;
      (i_opcode == OPC_BRANCH):   o_fmt = FMT_B;
      (i_opcode == OPC_OP):       o_fmt = FMT_R;
      default:                    o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_decode_stage.sv
// Two-entry decode skid buffer between fetch and execute.
// Optional perf counters enabled by INST_DECODE_PERF_EN.
module inst_decode_stage
  import cpu_defs::*;
#(
  parameter int          DEPTH            = 2,
  parameter logic [31:0] RESET_PC_INVALID = 32'h0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  inst_decode_stage_if.slave  bus
`ifdef INST_DECODE_PERF_EN
  ,
  output logic [31:0]         decoded_count,
  output logic [15:0]         illegal_count
`endif
);

  localparam dec_ent_t ENT_BLANK = '{
    inst:    RESET_PC_INVALID,
    pc:      RESET_PC_INVALID,
    imm:     RESET_PC_INVALID,
    fmt:     FMT_R,
    illegal: 1'b0
  };

  state_e      r_state;
  state_e      w_next;
  dec_ent_t    r_ent [DEPTH];
  dec_ent_t    w_new;
  fmt_e        w_fmt;
  logic        w_illegal;
  logic [31:0] w_imm;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_push;
  logic        w_pop;
  logic        w_wr;

  inst_opcode_classify u_classify (
    .i_opcode  (bus.in_inst[6:0]),
    .o_fmt     (w_fmt),
    .o_illegal (w_illegal)
  );

  inst_immediate_decode u_imm (
    .i_inst  (bus.in_inst[31:7]),
    .o_imm_i (w_imm_i),
    .o_imm_s (w_imm_s),
    .o_imm_b (w_imm_b),
    .o_imm_u (w_imm_u),
    .o_imm_j (w_imm_j)
  );

  always_comb begin
    w_imm = 32'h0;
    unique case (w_fmt)
      FMT_I:   w_imm = w_imm_i;
      FMT_S:   w_imm = w_imm_s;
      FMT_B:   w_imm = w_imm_b;
      FMT_U:   w_imm = w_imm_u;
      FMT_J:   w_imm = w_imm_j;
      default: w_imm = 32'h0;
    endcase
  end

  assign w_new = '{
    inst:    bus.in_inst,
    pc:      bus.in_pc,
    imm:     w_imm,
    fmt:     w_fmt,
    illegal: w_illegal
  };

  assign w_in_ready  = !reset && (r_state != ST_FULL);
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;
  // A flushed push is consumed by fetch but never stored
  assign w_wr        = w_push && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_push) w_next = ST_ONE;
      ST_ONE: begin
        if (w_push && !w_pop)      w_next = ST_FULL;
        else if (w_pop && !w_push) w_next = ST_EMPTY;
      end
      ST_FULL:  if (w_pop) w_next = ST_ONE;
      default:  w_next = ST_EMPTY;
    endcase
    if (flush) w_next = ST_EMPTY;
  end

  always_comb begin
    bus.in_ready  = w_in_ready;
    bus.out_valid = w_out_valid;
    if (w_out_valid) begin
      bus.out_inst    = r_ent[0].inst;
      bus.out_pc      = r_ent[0].pc;
      bus.out_imm     = r_ent[0].imm;
      bus.out_fmt     = r_ent[0].fmt;
      bus.out_illegal = r_ent[0].illegal;
    end else begin
      bus.out_inst    = RESET_PC_INVALID;
      bus.out_pc      = RESET_PC_INVALID;
      bus.out_imm     = RESET_PC_INVALID;
      bus.out_fmt     = FMT_R;
      bus.out_illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_ent[k] <= ENT_BLANK;
      end
    end else begin
      if (w_wr && (r_state == ST_EMPTY ||
                   (r_state == ST_ONE && w_pop))) begin
        r_ent[0] <= w_new;
      end else if (w_pop && r_state == ST_FULL) begin
        r_ent[0] <= r_ent[1];
      end
      if (w_wr && r_state == ST_ONE && !w_pop) begin
        r_ent[1] <= w_new;
      end
    end
  end

`ifdef INST_DECODE_PERF_EN
  logic [31:0] r_dec_cnt;
  logic [15:0] r_ill_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dec_cnt <= 32'h0;
      r_ill_cnt <= 16'h0;
    end else begin
      if (w_pop) r_dec_cnt <= r_dec_cnt + 32'd1;
      if (w_pop && r_ent[0].illegal &&
          r_ill_cnt != 16'hFFFF) begin
        r_ill_cnt <= r_ill_cnt + 16'd1;
      end
    end
  end

  assign decoded_count = r_dec_cnt;
  assign illegal_count = r_ill_cnt;
`endif

endmodule
